// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: drain FSM states,
// byte and data-port widths, and a helper that packs a byte onto the
// 32-bit data-write port.
package uart_pkg;

  localparam int BYTE_W = 8;
  localparam int DAT_W  = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } drain_state_t;

  // Zero-extend a byte to the UART data-port width.
  function automatic logic [DAT_W-1:0] dat_word(input logic [BYTE_W-1:0] b);
    return {{(DAT_W-BYTE_W){1'b0}}, b};
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte queue, 2**ADDR_W entries deep.
// The level counter is kept separately from the pointers, so full and empty
// need no extra wrap bit. Flush clears the pointers and the level, and wins
// over push and pop. The storage array is not reset.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [BYTE_W-1:0] pop_data,
  output logic [ADDR_W:0]   level,
  output logic              empty,
  output logic              full
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LVL_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] LVL_ZERO = '0;
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0]   lvl_nxt;
  logic              wr_en, rd_en;

  // Local guards: the caller already qualifies push and pop, but an
  // unqualified request must never corrupt the queue.
  assign wr_en = push && !full  && !flush;
  assign rd_en = pop  && !empty && !flush;

  assign pop_data = mem[rptr];

  // Next level: flush clears it, and a simultaneous push and pop cancel out.
  always_comb begin
    lvl_nxt = level;
    if (flush)
      lvl_nxt = LVL_ZERO;
    else if (wr_en && !rd_en)
      lvl_nxt = level + LVL_ONE;
    else if (rd_en && !wr_en)
      lvl_nxt = level - LVL_ONE;
  end

  // Storage write. No reset, so this infers plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wptr] <= push_data;
  end

  // Pointers wrap naturally at the depth.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + PTR_ONE;
      if (rd_en) rptr <= rptr + PTR_ONE;
    end
  end

  // The level and the full/empty flags are all registered from the same
  // next value, so they stay consistent with each other.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      level <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      level <= lvl_nxt;
      empty <= (lvl_nxt == LVL_ZERO);
      full  <= (lvl_nxt == LVL_FULL);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte queue in front of the simpleuart data-write port.
// Software pushes bytes. A two-state drain FSM pops one byte at a time into
// an output register and holds the write strobe until the core stops
// stalling.
// Optional feature: define UART_TXFIFO_OVF_EN to add a sticky overflow flag
// (ovf) and its clear input (ovf_clr).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push_valid,
  input  logic [BYTE_W-1:0] push_data,
  output logic              push_ready,
  input  logic              flush,
  input  logic              uart_enabled,
  output logic              reg_dat_we,
  output logic [DAT_W-1:0]  reg_dat_di,
  input  logic              reg_dat_wait,
  output logic [ADDR_W:0]   level,
  output logic              empty,
  output logic              full
`ifdef UART_TXFIFO_OVF_EN
  ,
  output logic              ovf,
  input  logic              ovf_clr
`endif
);

  drain_state_t      state, state_nxt;
  logic              pop;
  logic [BYTE_W-1:0] pop_data;
  logic [BYTE_W-1:0] dat_q;

  assign push_ready = !full && !flush;

  uart_byte_fifo #(.ADDR_W(ADDR_W)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push_valid && push_ready),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .pop_data  (pop_data),
    .level     (level),
    .empty     (empty),
    .full      (full)
  );

  // Drain state register.
  always_ff @(posedge clk) begin
    if (!resetn)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Drain next state. A write in progress is not dropped when the enable
  // falls. Only a flush or a reset abandons it.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pop)                    state_nxt = WRITE;
      WRITE:   if (flush || !reg_dat_wait) state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  // Drain outputs: pop when idle with data and enabled, and strobe while in WRITE.
  always_comb begin
    pop        = (state == IDLE) && !empty && uart_enabled && !flush;
    reg_dat_we = (state == WRITE);
  end

  // Output byte register. It is loaded on pop and holds steady through any stall.
  always_ff @(posedge clk) begin
    if (!resetn)
      dat_q <= '0;
    else if (pop)
      dat_q <= pop_data;
  end

  assign reg_dat_di = dat_word(dat_q);

`ifdef UART_TXFIFO_OVF_EN
  // Sticky overflow. It sets on a push refused for fullness, and set beats
  // clear. A flush leaves it alone.
  always_ff @(posedge clk) begin
    if (!resetn)
      ovf <= 1'b0;
    else if (push_valid && full && !flush)
      ovf <= 1'b1;
    else if (ovf_clr)
      ovf <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo (ADDR_W=4). Stimulus pushes the
// expected delivered words into a queue. A negedge monitor pops and compares
// every accepted write.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        resetn, push_valid, flush, uart_enabled, reg_dat_wait;
  logic [7:0]  push_data;
  logic        push_ready, reg_dat_we, empty, full;
  logic [31:0] reg_dat_di;
  logic [4:0]  level;
  logic        ovf, ovf_clr;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.ADDR_W(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .push_valid   (push_valid),
    .push_data    (push_data),
    .push_ready   (push_ready),
    .flush        (flush),
    .uart_enabled (uart_enabled),
    .reg_dat_we   (reg_dat_we),
    .reg_dat_di   (reg_dat_di),
    .reg_dat_wait (reg_dat_wait),
    .level        (level),
    .empty        (empty),
    .full         (full)
`ifdef UART_TXFIFO_OVF_EN
    ,
    .ovf          (ovf),
    .ovf_clr      (ovf_clr)
`endif
  );

`ifndef UART_TXFIFO_OVF_EN
  assign ovf = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit expect_out);
    push_valid = 1'b1;
    push_data  = b;
    if (expect_out) exp_q.push_back({24'h0, b});
    tick();
    push_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || reg_dat_we) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_drain: %0d bytes still pending after %0d cycles, expected 0", name, exp_q.size(), budget);
    end
    chk({name, "_level_after"}, 32'(level), 32'd0);
  endtask

  // Monitor: a write is accepted when the strobe is high and the core is not stalling.
  always @(negedge clk) begin
    if (resetn === 1'b1 && reg_dat_we === 1'b1 && reg_dat_wait === 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got 0x%0h expected no write", reg_dat_di);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (reg_dat_di !== e) begin
          failures++;
          $display("FAIL deliver: got 0x%0h expected 0x%0h", reg_dat_di, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; push_valid = 1'b0; push_data = 8'h00; flush = 1'b0;
    uart_enabled = 1'b1; reg_dat_wait = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    chk("rst_we", 32'(reg_dat_we), 32'd0);
    chk("rst_di", reg_dat_di, 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ready", 32'(push_ready), 32'd1);
    chk("rst_ovf", 32'(ovf), 32'd0);
    resetn = 1'b1;
    tick();

    // Single byte: the strobe is high exactly one cycle, two edges after the push.
    push_byte(8'hA5, 1'b1);
    chk("single_level_n1", 32'(level), 32'd1);
    chk("single_empty_n1", 32'(empty), 32'd0);
    tick();
    chk("single_we_n2", 32'(reg_dat_we), 32'd1);
    chk("single_di_n2", reg_dat_di, 32'h000000A5);
    chk("single_level_n2", 32'(level), 32'd0);
    tick();
    chk("single_we_off", 32'(reg_dat_we), 32'd0);
    wait_drain("single", 10);

    // Stall: the first byte is held on the port while the core waits.
    reg_dat_wait = 1'b1;
    push_byte(8'h11, 1'b1);
    push_byte(8'h22, 1'b1);
    push_byte(8'h33, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (i == 0 || i == 10 || i == 19) begin
        chk("stall_we", 32'(reg_dat_we), 32'd1);
        chk("stall_di", reg_dat_di, 32'h00000011);
        chk("stall_level", 32'(level), 32'd2);
      end
      tick();
    end
    reg_dat_wait = 1'b0;
    wait_drain("stall", 40);

    // Fill with drain disabled: 16 pushes are accepted and the 17th is dropped.
    uart_enabled = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i == 16) begin
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ready", 32'(push_ready), 32'd0);
      end
      push_byte(8'(8'h40 + i), i < 16);
    end
    chk("fill_level", 32'(level), 32'd16);
`ifdef UART_TXFIFO_OVF_EN
    chk("fill_ovf", 32'(ovf), 32'd1);
`endif
    uart_enabled = 1'b1;
    wait_drain("fill", 100);
`ifdef UART_TXFIFO_OVF_EN
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'd0);
`endif

    // Flush during WRITE with five bytes still queued.
    uart_enabled = 1'b0;
    for (int i = 0; i < 6; i++) push_byte(8'(8'hB0 + i), 1'b1);
    uart_enabled = 1'b1;
    reg_dat_wait = 1'b1;
    tick();
    chk("flush_pre_level", 32'(level), 32'd5);
    chk("flush_pre_we", 32'(reg_dat_we), 32'd1);
    flush = 1'b1;
    exp_q.delete();
    tick();
    flush = 1'b0;
    chk("flush_we", 32'(reg_dat_we), 32'd0);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    reg_dat_wait = 1'b0;
    push_byte(8'h7E, 1'b1);
    wait_drain("flush", 10);

    // A push and a pop on the same edge at level 3, then a reset during WRITE.
    uart_enabled = 1'b0;
    push_byte(8'hC1, 1'b0);
    push_byte(8'hC2, 1'b0);
    push_byte(8'hC3, 1'b0);
    chk("conc_pre_level", 32'(level), 32'd3);
    uart_enabled = 1'b1;
    reg_dat_wait = 1'b1;
    push_byte(8'hC4, 1'b0);
    chk("conc_level", 32'(level), 32'd3);
    chk("conc_we", 32'(reg_dat_we), 32'd1);
    chk("conc_di", reg_dat_di, 32'h000000C1);
    resetn = 1'b0;
    tick();
    chk("mid_rst_we", 32'(reg_dat_we), 32'd0);
    chk("mid_rst_di", reg_dat_di, 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_full", 32'(full), 32'd0);
    chk("mid_rst_ready", 32'(push_ready), 32'd1);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    resetn = 1'b1;
    reg_dat_wait = 1'b0;
    tick(); tick();
    chk("post_rst_we", 32'(reg_dat_we), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
